// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle MIPS core: next-PC selection,
// kernel-mode tracking, pending-interrupt latch and return-address generation.
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
   parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic [2:0]  PCSrc,
   input  logic        Exception,
   input  logic        BranchCond,
   input  logic [15:0] Imm16,
   input  logic [25:0] JT,
   input  logic [31:0] DataBusA,
   input  logic        IRQ_in,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4,
   output logic [31:0] ReturnAddr,
   output logic        ker,
   output logic        IRQ
);

   localparam logic [2:0] SRC_SEQ = 3'd0;
   localparam logic [2:0] SRC_BR  = 3'd1;
   localparam logic [2:0] SRC_J   = 3'd2;
   localparam logic [2:0] SRC_JR  = 3'd3;
   localparam logic [2:0] SRC_INT = 3'd4;

   logic [31:0]        pc_q;
   logic               pend;
   logic               guard;
   logic [31:0]        next_pc;
   logic [31:0]        br_target;
   logic [31:0]        j_target;
   logic [31:0]        jr_target;
   logic signed [31:0] br_off;
   logic               take_exc;
   logic               take_int;
   logic               pend_next;
   logic               guard_next;

   function automatic logic signed [31:0] branch_offset(input logic signed [15:0] imm);
      return $signed({{14{imm[15]}}, imm, 2'b00});
   endfunction

   // Branches and jumps may compute an address in the other half of the map;
   // the mode bit is pinned so they can never change privilege.
   function automatic logic [31:0] keep_mode(input logic [31:0] target, input logic mode);
      return {mode, target[30:0]};
   endfunction

   assign PC       = pc_q;
   assign PC_plus4 = pc_q + 32'd4;
   assign ker      = pc_q[31];
   assign IRQ      = pend & ~guard;

   assign br_off    = branch_offset($signed(Imm16));
   assign br_target = keep_mode(PC_plus4 + $unsigned(br_off), ker);
   assign j_target  = keep_mode({PC_plus4[31:28], JT, 2'b00}, ker);
   assign jr_target = {ker & DataBusA[31], DataBusA[30:0]};

   assign take_exc = Exception & ~ker;
   assign take_int = (PCSrc == SRC_INT) & ~ker & ~take_exc;

   // The interrupted instruction re-executes; a faulting one is skipped.
   assign ReturnAddr = take_int ? pc_q : PC_plus4;

   always_comb begin
      next_pc = PC_plus4;
      if (take_exc) begin
         next_pc = XADR_PC;
      end else if (take_int) begin
         next_pc = ILLOP_PC;
      end else begin
         unique case (PCSrc)
            SRC_JR:  next_pc = jr_target;
            SRC_J:   next_pc = j_target;
            SRC_BR:  next_pc = BranchCond ? br_target : PC_plus4;
            default: next_pc = PC_plus4;
         endcase
      end
   end

   // A request arriving on the taking edge wins over the clear.
   always_comb begin
      pend_next  = pend;
      guard_next = guard;
      if (IRQ_in) begin
         pend_next = 1'b1;
      end else if (take_int && !Stall) begin
         pend_next = 1'b0;
      end
      if (!Stall) begin
         guard_next = ker & ~next_pc[31];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         pend  <= 1'b0;
         guard <= 1'b0;
      end else begin
         pend  <= pend_next;
         guard <= guard_next;
         if (!Stall) begin
            pc_q <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: expected PCs are queued as stimulus is driven
// and compared after the edge that produces them.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Stall = 1'b0;
   logic [2:0]  PCSrc = 3'd0;
   logic        Exception = 1'b0;
   logic        BranchCond = 1'b0;
   logic [15:0] Imm16 = 16'h0;
   logic [25:0] JT = 26'h0;
   logic [31:0] DataBusA = 32'h0;
   logic        IRQ_in = 1'b0;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic [31:0] ReturnAddr;
   logic        ker;
   logic        IRQ;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_pc;

   pc_unit dut (
      .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc), .Exception(Exception),
      .BranchCond(BranchCond), .Imm16(Imm16), .JT(JT), .DataBusA(DataBusA),
      .IRQ_in(IRQ_in), .PC(PC), .PC_plus4(PC_plus4), .ReturnAddr(ReturnAddr),
      .ker(ker), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [2:0] src, input logic exc, input logic bc,
                        input logic [15:0] imm, input logic [25:0] jt,
                        input logic [31:0] dba, input logic irq, input logic stl);
      PCSrc = src; Exception = exc; BranchCond = bc; Imm16 = imm;
      JT = jt; DataBusA = dba; IRQ_in = irq; Stall = stl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [2:0] src, input logic exc, input logic bc,
                      input logic [15:0] imm, input logic [25:0] jt,
                      input logic [31:0] dba, input logic irq, input logic stl,
                      input logic [31:0] expected);
      drive(src, exc, bc, imm, jt, dba, irq, stl);
      sb.push_back(expected);
      tick();
   endtask

   task automatic apply_reset();
      drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++; if (PC !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h8000_0000); end
      checks++; if (ker !== 1'b1) begin failures++; $display("FAIL reset_ker got=%b exp=1", ker); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
      checks++; if (PC_plus4 !== 32'h8000_0004) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", PC_plus4, 32'h8000_0004); end
      @(posedge clk);
      #1 reset = 1'b1;
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0004);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL rst_seq1 got=%h exp=%h", PC, exp_pc); end
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0008);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL rst_seq2 got=%h exp=%h", PC, exp_pc); end
      // mid-cycle reset must act before the next edge
      #3 reset = 1'b0;
      #1;
      checks++; if (PC !== 32'h8000_0000) begin failures++; $display("FAIL async_reset got=%h exp=%h", PC, 32'h8000_0000); end
      #1 reset = 1'b1;
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0004);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL rst_resume got=%h exp=%h", PC, exp_pc); end
   endtask

   task automatic test_branch();
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h0040_0010, 0, 0, 32'h0040_0010);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jr_to_user got=%h exp=%h", PC, exp_pc); end
      checks++; if (ker !== 1'b0) begin failures++; $display("FAIL user_ker got=%b exp=0", ker); end
      cyc(3'd1, 0, 1, 16'hFFFC, 26'h0, 32'h0, 0, 0, 32'h0040_0004);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL br_back got=%h exp=%h", PC, exp_pc); end
      cyc(3'd1, 0, 1, 16'h0002, 26'h0, 32'h0, 0, 0, 32'h0040_0010);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL br_fwd got=%h exp=%h", PC, exp_pc); end
      cyc(3'd1, 0, 0, 16'hFFFC, 26'h0, 32'h0, 0, 0, 32'h0040_0014);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL br_not_taken got=%h exp=%h", PC, exp_pc); end
   endtask

   task automatic test_jump();
      cyc(3'd1, 0, 1, 16'hFFFA, 26'h0, 32'h0, 0, 0, 32'h0040_0000);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL br_to_jbase got=%h exp=%h", PC, exp_pc); end
      cyc(3'd2, 0, 0, 16'h0, 26'h010_0040, 32'h0, 0, 0, 32'h0040_0100);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jump got=%h exp=%h", PC, exp_pc); end
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h8000_1234, 0, 0, 32'h0000_1234);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jr_user_blocked got=%h exp=%h", PC, exp_pc); end
      cyc(3'd0, 1, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0008);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL exc_entry got=%h exp=%h", PC, exp_pc); end
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h8000_1234, 0, 0, 32'h8000_1234);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jr_kernel got=%h exp=%h", PC, exp_pc); end
      checks++; if (ker !== 1'b1) begin failures++; $display("FAIL jr_kernel_ker got=%b exp=1", ker); end
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h7FFF_FFFC, 0, 0, 32'h7FFF_FFFC);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jr_top_user got=%h exp=%h", PC, exp_pc); end
      // PC_plus4 wraps into kernel space; the jump must stay in user mode
      cyc(3'd2, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0000_0000);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL jump_keep_mode got=%h exp=%h", PC, exp_pc); end
      cyc(3'd1, 0, 1, 16'hFFF8, 26'h0, 32'h0, 0, 0, 32'h7FFF_FFE4);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL br_wrap_keep_mode got=%h exp=%h", PC, exp_pc); end
      cyc(3'd5, 0, 1, 16'hFFF8, 26'h0, 32'h0, 0, 0, 32'h7FFF_FFE8);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL src5_seq got=%h exp=%h", PC, exp_pc); end
   endtask

   task automatic test_interrupt();
      cyc(3'd0, 1, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0008);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL int_setup_exc got=%h exp=%h", PC, exp_pc); end
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h0040_001C, 0, 0, 32'h0040_001C);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL int_setup_jr got=%h exp=%h", PC, exp_pc); end
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h0040_0020);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL int_pulse_pc got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL int_irq_raised got=%b exp=1", IRQ); end
      drive(3'd4, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
      #1;
      checks++; if (ReturnAddr !== 32'h0040_0020) begin failures++; $display("FAIL int_retaddr got=%h exp=%h", ReturnAddr, 32'h0040_0020); end
      sb.push_back(32'h8000_0004);
      tick();
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL int_entry got=%h exp=%h", PC, exp_pc); end
      checks++; if (ker !== 1'b1) begin failures++; $display("FAIL int_ker got=%b exp=1", ker); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL int_pend_clear got=%b exp=0", IRQ); end
   endtask

   task automatic test_irq_held_guard();
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h8000_0008);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL held_seq got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL held_irq got=%b exp=1", IRQ); end
      cyc(3'd4, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_000C);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL kernel_src4_seq got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL kernel_src4_pend got=%b exp=1", IRQ); end
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h0040_0020, 0, 0, 32'h0040_0020);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL eret_jr got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL guard_masks got=%b exp=0", IRQ); end
      cyc(3'd2, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 32'h0040_0020);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL guard_stall_pc got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL guard_stall_irq got=%b exp=0", IRQ); end
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0040_0024);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL guard_one_instr got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL guard_release got=%b exp=1", IRQ); end
      cyc(3'd4, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h8000_0004);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL take_with_irq got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL set_beats_clear got=%b exp=1", IRQ); end
   endtask

   task automatic test_exception_stall();
      apply_reset();
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h0040_0040, 0, 0, 32'h0040_0040);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL exc_setup got=%h exp=%h", PC, exp_pc); end
      drive(3'd2, 1, 0, 16'h0, 26'h010_0040, 32'h0, 0, 0);
      #1;
      checks++; if (ReturnAddr !== 32'h0040_0044) begin failures++; $display("FAIL exc_retaddr got=%h exp=%h", ReturnAddr, 32'h0040_0044); end
      sb.push_back(32'h8000_0008);
      tick();
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL exc_over_jump got=%h exp=%h", PC, exp_pc); end
      cyc(3'd0, 1, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_000C);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL exc_ignored_kernel got=%h exp=%h", PC, exp_pc); end
      for (int i = 0; i < 3; i++) begin
         cyc(3'd2, 0, 0, 16'h0, 26'h0, 32'h0, (i == 1), 1, 32'h8000_000C);
         exp_pc = sb.pop_front(); checks++;
         if (PC !== exp_pc) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, PC, exp_pc); end
      end
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0010);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL stall_resume got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL stall_irq_set got=%b exp=1", IRQ); end
   endtask

   task automatic test_back_to_back();
      cyc(3'd3, 0, 0, 16'h0, 26'h0, 32'h0040_0100, 0, 0, 32'h0040_0100);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL b2b_jr got=%h exp=%h", PC, exp_pc); end
      cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0040_0104);
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL b2b_seq got=%h exp=%h", PC, exp_pc); end
      drive(3'd4, 1, 0, 16'h0, 26'h0, 32'h0, 0, 0);
      #1;
      checks++; if (ReturnAddr !== 32'h0040_0108) begin failures++; $display("FAIL exc_int_retaddr got=%h exp=%h", ReturnAddr, 32'h0040_0108); end
      sb.push_back(32'h8000_0008);
      tick();
      exp_pc = sb.pop_front(); checks++;
      if (PC !== exp_pc) begin failures++; $display("FAIL exc_beats_int got=%h exp=%h", PC, exp_pc); end
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL exc_keeps_pend got=%b exp=1", IRQ); end
      for (int i = 1; i <= 4; i++) begin
         cyc(3'd0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h8000_0008 + 32'(4 * i));
         exp_pc = sb.pop_front(); checks++;
         if (PC !== exp_pc) begin failures++; $display("FAIL b2b_run%0d got=%h exp=%h", i, PC, exp_pc); end
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jump();
      test_interrupt();
      test_irq_held_guard();
      test_exception_stall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS core, directly upstream of the control decoder.
- Holds the PC and computes the next PC from the decoder's PCSrc selection.
- Latches and presents pending interrupts to the decoder and drives the kernel-mode flag `ker`.
- Produces the return address written back by jal/jalr and by interrupt/exception entry.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset (kernel space).
- ILLOP_PC, 32'h80000004, interrupt handler entry.
- XADR_PC, 32'h80000008, exception handler entry.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Stall  input  1  hold PC and all state this cycle.
- PCSrc  input  3  next-PC select from the decoder: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 interrupt.
- Exception  input  1  illegal-instruction flag from the decoder.
- BranchCond  input  1  ALU compare result (ALUOut[0]); branch taken when 1.
- Imm16  input  16  branch offset from the instruction.
- JT  input  26  jump target field from the instruction.
- DataBusA  input  32  rs value, used as the jr/jalr target.
- IRQ_in  input  1  timer/peripheral interrupt request, level, same clock domain.
- PC  output  32  current instruction address.
- PC_plus4  output  32  PC+4.
- ReturnAddr  output  32  value written to $ra/$k0 via MemtoReg=2.
- ker  output  1  kernel mode, equal to PC[31].
- IRQ  output  1  pending interrupt presented to the decoder.

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, pend=0, guard=0.
  - Resulting outputs: ker=1, IRQ=0, PC_plus4=RESET_PC+4.
- Outputs:
  - PC_plus4 = PC+4, 32-bit wrap. ker = PC[31]. IRQ = pend & ~guard (combinational).
- Branch target: PC_plus4 + (sign-extend(Imm16) << 2), mod 2^32.
- Jump target: {PC_plus4[31:28], JT, 2'b00}.
- Next PC, per rising edge with Stall=0, priority high to low:
  1. Exception & ~ker: XADR_PC.
  2. PCSrc=4 & ~ker: ILLOP_PC. If PCSrc=4 & ker: treat as PCSrc=0.
  3. PCSrc=3: {PC[31] & DataBusA[31], DataBusA[30:0]}. User mode can never set bit 31; kernel may leave.
  4. PCSrc=2: jump target.
  5. PCSrc=1: branch target if BranchCond=1, else PC_plus4.
  6. PCSrc=0, or 5..7: PC_plus4.
- Kernel bit preservation:
  - For PCSrc 1/2 the next PC[31] is forced to the current PC[31].
  - A branch or jump never changes mode.
- Exception and PCSrc asserted together: exception wins. Exception while ker=1 is ignored (sequential path).
- Pending interrupt (pend):
  - Set on any edge where IRQ_in=1.
  - Cleared on the edge that takes the interrupt (PCSrc=4, ker=0, Stall=0, no Exception).
  - If IRQ_in=1 on the taking edge, set has priority: pend stays 1.
  - pend is held, not lost, while ker=1.
- Return guard:
  - guard=1 for exactly one instruction after a kernel-to-user transition (ker 1 to 0).
  - Guarantees one user instruction executes per interrupt return.
  - Cleared on the next non-stalled edge. Stall extends it.
- ReturnAddr (combinational):
  - Interrupt selected: PC, so the interrupted instruction re-executes.
  - Exception selected: PC_plus4, skipping the faulting instruction.
  - Otherwise: PC_plus4.
- Stall=1: PC, pend and guard hold. IRQ_in during stall still sets pend.
- Reset mid-operation: state returns to reset values immediately, independent of clk.

Test Plan:
- Reset sequence: reset low mid-cycle → PC=0x80000000 before the next edge, ker=1, IRQ=0. Release reset with PCSrc=0 → PC=0x80000004, then 0x80000008.
- Branches: PC=0x00400010, PCSrc=1, Imm16=0xFFFC, BranchCond=1 → PC=0x00400004. Same with BranchCond=0 → PC=0x00400014.
- Jump and jr:
  - PC=0x00400000, PCSrc=2, JT=0x0100040 → PC=0x00400100.
  - User mode, PCSrc=3, DataBusA=0x80001234 → PC=0x00001234 (bit 31 blocked).
  - Kernel mode, same DataBusA → PC=0x80001234.
- Interrupt entry: user PC=0x00400020, IRQ_in pulse of 1 cycle → IRQ=1 next cycle. Drive PCSrc=4 → ReturnAddr=0x00400020, PC=0x80000004, pend cleared, ker=1.
- Interrupt held in kernel, then guard: IRQ_in pulse while ker=1 → pend held. Then jr to 0x00400020 → IRQ=0 for exactly one instruction, then IRQ=1.
- Exception priority and stall:
  - User mode, Exception=1 with PCSrc=2 → PC=0x80000008, ReturnAddr=old PC+4.
  - Stall=1 for 3 cycles → PC unchanged, then resumes.
